// File: rtl/wb_mem_responder.sv
// rtl/wb_mem_responder.sv - Wishbone B4 slave answering from an internal word-addressed RAM
//
// Purpose: known-latency golden responder and loopback target for the master
// that normally drives the SDRAM-controller Wishbone port. Every access waits
// WAIT_CYCLES cycles before its first acknowledge.
//
// Build option: define WB_RESP_BURST_EN to add incrementing bursts
// (cti 010 at acceptance enters BURST, cti 111 on an acked beat ends it).
// Without it wb_cti_i is ignored and every beat is a classic cycle.
//
// Ports:
//   sys_clk     clock, all logic on the rising edge
//   RESETN      synchronous active-low reset
//   wb_cyc_i    bus cycle valid
//   wb_stb_i    strobe
//   wb_we_i     1 = write, 0 = read
//   wb_addr_i   byte address (upper bits alias)
//   wb_dat_i    write data
//   wb_sel_i    byte enables for writes
//   wb_cti_i    cycle type (000 classic, 010 incrementing, 111 end of burst)
//   wb_ack_o    acknowledge
//   wb_dat_o    registered read data, valid while wb_ack_o is high on a read
//   busy_o      high from request acceptance through the last ack
module wb_mem_responder #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            sys_clk,
  input  logic            RESETN,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic [2:0]      wb_cti_i,
  output logic            wb_ack_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic            busy_o
);

  localparam int NB    = DW / 8;
  localparam int BW    = $clog2(NB);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ACK   = 2'd2
`ifdef WB_RESP_BURST_EN
    , S_BURST = 2'd3
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
  logic                  we_q, we_d;
  logic                  after_ack_q;
  logic [DW-1:0]         rdata_q;
  logic                  rd_load;
  logic                  mem_wr;
  logic                  ack;
  logic [DEPTH_LOG2-1:0] req_word;
  logic                  unused_bits;
`ifdef WB_RESP_BURST_EN
  logic                  burst_q, burst_d;
`endif

  logic [DW-1:0] mem [DEPTH];

  assign req_word    = wb_addr_i[BW+DEPTH_LOG2-1:BW];
  assign unused_bits = ^{wb_addr_i, wb_cti_i};

  // rd_load fetches mem[ptr_d] so the data register already holds the word
  // for the cycle in which that word is acknowledged.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we_d    = we_q;
`ifdef WB_RESP_BURST_EN
    burst_d = burst_q;
`endif
    rd_load = 1'b0;
    mem_wr  = 1'b0;
    ack     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The cycle right after a classic ack is never an acceptance cycle.
        if (wb_cyc_i && wb_stb_i && !after_ack_q) begin
          ptr_d = req_word;
          we_d  = wb_we_i;
          cnt_d = 4'(WAIT_CYCLES);
`ifdef WB_RESP_BURST_EN
          burst_d = (wb_cti_i == 3'b010);
`endif
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACK;
            rd_load = !wb_we_i;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_ACK;
          rd_load = !we_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK: begin
        ack     = 1'b1;
        mem_wr  = we_q;
        state_d = S_IDLE;
      end
`ifdef WB_RESP_BURST_EN
      S_BURST: begin
        if (!wb_cyc_i) begin
          state_d = S_IDLE;
        end else if (wb_stb_i) begin
          ack    = 1'b1;
          mem_wr = we_q;
          ptr_d  = ptr_q + DEPTH_LOG2'(1);
          if (wb_cti_i == 3'b111) begin
            state_d = S_IDLE;
          end else begin
            rd_load = !we_q;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef WB_RESP_BURST_EN
    // Entry into the first-ack state is shared; bursts divert to BURST.
    if (burst_d && (state_d == S_ACK)) begin
      state_d = S_BURST;
    end
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (!RESETN) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      ptr_q       <= '0;
      we_q        <= 1'b0;
      after_ack_q <= 1'b0;
      rdata_q     <= '0;
`ifdef WB_RESP_BURST_EN
      burst_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      we_q        <= we_d;
      after_ack_q <= (state_q == S_ACK);
      if (rd_load) begin
        rdata_q <= mem[ptr_d];
      end
`ifdef WB_RESP_BURST_EN
      burst_q     <= burst_d;
`endif
    end
  end

  // RAM is not reset; a write in a reset cycle is dropped.
  always_ff @(posedge sys_clk) begin
    if (RESETN && mem_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (wb_sel_i[b]) begin
          mem[ptr_q][b*8 +: 8] <= wb_dat_i[b*8 +: 8];
        end
      end
    end
  end

  assign wb_ack_o = ack;
  assign wb_dat_o = rdata_q;
  assign busy_o   = (state_q != S_IDLE);

endmodule

// File: tb/tb_wb_mem_responder.sv
// tb/tb_wb_mem_responder.sv - self-checking bench for wb_mem_responder
module tb_wb_mem_responder;

  localparam int W = 2;

  logic        clk;
  logic        rstn;
  logic        cyc, stb, we;
  logic [31:0] addr, dat;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic        ack;
  logic [31:0] dato;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [1024];

  wb_mem_responder #(
    .AW(32), .DW(32), .DEPTH_LOG2(10), .WAIT_CYCLES(W)
  ) dut (
    .sys_clk   (clk),
    .RESETN    (rstn),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_we_i   (we),
    .wb_addr_i (addr),
    .wb_dat_i  (dat),
    .wb_sel_i  (sel),
    .wb_cti_i  (cti),
    .wb_ack_o  (ack),
    .wb_dat_o  (dato),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] widx(input logic [31:0] a);
    return a[11:2];
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = model_mem[widx(a)];
    for (int b = 0; b < 4; b++) begin
      if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
    end
    model_mem[widx(a)] = v;
  endtask

  // One classic access. lat = negedge index of the ack (request driven in index 0).
  task automatic wb_classic(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] c,
                            output int lat, output logic [31:0] rd,
                            output logic busy_ok, output logic tail_ok);
    lat = -1;
    rd = 'x;
    busy_ok = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; dat = d; sel = s; cti = c;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k == 0 && busy !== 1'b0) busy_ok = 1'b0;
      if (k >= 1 && busy !== 1'b1) busy_ok = 1'b0;
      if (ack === 1'b1) begin
        lat = k;
        rd = dato;
        break;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
    @(negedge clk);
    tail_ok = (ack === 1'b0) && (busy === 1'b0);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; dat = '0; sel = '0; cti = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
    checks++; if (dato !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h expected 00000000", dato); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_classic;
    int lat; logic [31:0] rd; logic bok, tok;
    wb_classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, lat, rd, bok, tok);
    if (lat >= 0) model_write(32'h10, 32'hDEADBEEF, 4'hF);
    checks++; if (lat != W + 1) begin errors++; $display("FAIL classic_wr_lat: got %0d expected %0d", lat, W + 1); end
    checks++; if (!bok) begin errors++; $display("FAIL classic_wr_busy: got 0 expected 1"); end
    checks++; if (!tok) begin errors++; $display("FAIL classic_wr_tail: got 0 expected 1"); end
    wb_classic(1'b0, 32'h10, 32'h0, 4'hF, 3'b000, lat, rd, bok, tok);
    checks++; if (lat != W + 1) begin errors++; $display("FAIL classic_rd_lat: got %0d expected %0d", lat, W + 1); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL classic_rd_data: got %h expected deadbeef", rd); end
    checks++; if (!bok) begin errors++; $display("FAIL classic_rd_busy: got 0 expected 1"); end
    checks++; if (!tok) begin errors++; $display("FAIL classic_rd_tail: got 0 expected 1"); end
    // read data holds between acks
    checks++; if (dato !== 32'hDEADBEEF) begin errors++; $display("FAIL classic_rd_hold: got %h expected deadbeef", dato); end
  endtask

  task automatic test_byte_enable;
    int lat; logic [31:0] rd; logic bok, tok;
    wb_classic(1'b1, 32'h20, 32'h11223344, 4'hF, 3'b000, lat, rd, bok, tok);
    model_write(32'h20, 32'h11223344, 4'hF);
    wb_classic(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 3'b000, lat, rd, bok, tok);
    model_write(32'h20, 32'hAABBCCDD, 4'b0101);
    wb_classic(1'b0, 32'h20, 32'h0, 4'h0, 3'b000, lat, rd, bok, tok);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL be_partial: got %h expected 11bb33dd", rd); end
    wb_classic(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 3'b000, lat, rd, bok, tok);
    checks++; if (lat != W + 1) begin errors++; $display("FAIL be_sel0_ack_lat: got %0d expected %0d", lat, W + 1); end
    wb_classic(1'b0, 32'h20, 32'h0, 4'hF, 3'b000, lat, rd, bok, tok);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL be_sel0_unchanged: got %h expected 11bb33dd", rd); end
    // upper address bits alias onto the same word
    wb_classic(1'b0, 32'hFFFFF020, 32'h0, 4'hF, 3'b000, lat, rd, bok, tok);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL alias_read: got %h expected 11bb33dd", rd); end
  endtask

  task automatic test_back_to_back(input logic [2:0] c);
    int acks[$];
    int last;
    last = W + 1 + 3 * (W + 3);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h10; sel = 4'hF; cti = c;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        acks.push_back(k);
        checks++; if (dato !== model_mem[widx(32'h10)]) begin errors++; $display("FAIL b2b_data: got %h expected %h", dato, model_mem[widx(32'h10)]); end
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    checks++; if (acks.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", acks.size()); end
    for (int i = 0; i < acks.size() && i < 4; i++) begin
      checks++;
      if (acks[i] != W + 1 + i * (W + 3)) begin
        errors++; $display("FAIL b2b_ack_cycle[%0d]: got %0d expected %0d", i, acks[i], W + 1 + i * (W + 3));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_abort;
    int lat; logic [31:0] rd; logic bok, tok; logic late_ack;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h20; dat = 32'h0; sel = 4'hF; cti = 3'b000;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL abort_ack_wait: got %b expected 0", ack); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_wait: got %b expected 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b expected 0", busy); end
    late_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (ack !== 1'b0) late_ack = 1'b1;
      @(negedge clk);
    end
    checks++; if (late_ack) begin errors++; $display("FAIL abort_late_ack: got 1 expected 0"); end
    wb_classic(1'b0, 32'h20, 32'h0, 4'hF, 3'b000, lat, rd, bok, tok);
    checks++; if (rd !== model_mem[widx(32'h20)]) begin errors++; $display("FAIL abort_ram: got %h expected %h", rd, model_mem[widx(32'h20)]); end
  endtask

  task automatic test_random;
    int lat; logic [31:0] rd; logic bok, tok;
    logic [31:0] a, d; logic [3:0] s; logic w; logic [2:0] c;
    for (int i = 0; i < 16; i++) begin
      a = {12'h0, 8'h0, 10'(600 + i), 2'b00};
      d = $urandom;
      wb_classic(1'b1, a, d, 4'hF, 3'b000, lat, rd, bok, tok);
      model_write(a, d, 4'hF);
    end
    for (int n = 0; n < 50; n++) begin
      a = {20'($urandom), 10'(600 + $urandom_range(0, 15)), 2'($urandom)};
      d = $urandom;
      s = 4'($urandom);
      w = 1'($urandom_range(0, 1));
`ifdef WB_RESP_BURST_EN
      c = 3'b000;
`else
      c = 3'($urandom);
`endif
      wb_classic(w, a, d, s, c, lat, rd, bok, tok);
      checks++; if (lat != W + 1) begin errors++; $display("FAIL rand_lat[%0d]: got %0d expected %0d", n, lat, W + 1); end
      checks++; if (!tok || !bok) begin errors++; $display("FAIL rand_busy[%0d]: got %b%b expected 11", n, bok, tok); end
      if (w) begin
        model_write(a, d, s);
      end else begin
        checks++;
        if (rd !== model_mem[widx(a)]) begin
          errors++; $display("FAIL rand_rd[%0d]: got %h expected %h (addr %h)", n, rd, model_mem[widx(a)], a);
        end
      end
    end
  endtask

`ifdef WB_RESP_BURST_EN
  // 4-beat incrementing write burst; optional two-cycle master stall after beat stall_after.
  task automatic burst_write(input logic [31:0] a, input int stall_after);
    logic [31:0] d [4];
    int beat, k, stall_left;
    logic stalled, exp;
    logic [9:0] w0;
    for (int i = 0; i < 4; i++) d[i] = (stall_after < 0) ? 32'(i + 1) : $urandom;
    w0 = widx(a);
    beat = 0; k = 0; stall_left = 0; stalled = 1'b0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; dat = d[0]; sel = 4'hF; cti = 3'b010;
    while (beat < 4 && k < 40) begin
      @(negedge clk);
      exp = (k >= W + 1) && stb;
      checks++; if (ack !== exp) begin errors++; $display("FAIL burst_ack[k=%0d]: got %b expected %b", k, ack, exp); end
      if (exp) begin
        model_mem[w0 + 10'(beat)] = d[beat];
        beat++;
      end
      @(posedge clk); #1;
      k++;
      if (beat == 4) begin
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
      end else begin
        if (stall_left > 0) begin
          stall_left--;
          if (stall_left == 0) stb = 1'b1;
        end else if (exp && beat == stall_after && !stalled) begin
          stb = 1'b0; stall_left = 2; stalled = 1'b1;
        end
        dat = d[beat];
        cti = (beat == 3) ? 3'b111 : 3'b010;
      end
    end
    checks++; if (beat != 4) begin errors++; $display("FAIL burst_beats: got %0d expected 4", beat); end
    @(negedge clk);
    checks++; if (ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL burst_tail: got ack %b busy %b expected 0 0", ack, busy); end
  endtask

  task automatic test_burst_wrap;
    int lat; logic [31:0] rd; logic bok, tok;
    logic [31:0] ra [4];
    ra[0] = 32'h0000_0FF8; ra[1] = 32'h0000_0FFC; ra[2] = 32'h0000_0000; ra[3] = 32'h0000_0004;
    burst_write(32'h0000_3FF8, -1);
    for (int i = 0; i < 4; i++) begin
      wb_classic(1'b0, ra[i], 32'h0, 4'hF, 3'b000, lat, rd, bok, tok);
      checks++; if (rd !== 32'(i + 1)) begin errors++; $display("FAIL burst_wrap_rd[%0d]: got %h expected %h", i, rd, 32'(i + 1)); end
    end
  endtask

  task automatic test_burst_wait;
    int lat; logic [31:0] rd; logic bok, tok;
    logic [31:0] a;
    burst_write(32'h0000_0600, 2);
    for (int i = 0; i < 4; i++) begin
      a = 32'h0000_0600 + 32'(i * 4);
      wb_classic(1'b0, a, 32'h0, 4'hF, 3'b000, lat, rd, bok, tok);
      checks++; if (rd !== model_mem[widx(a)]) begin errors++; $display("FAIL burst_wait_rd[%0d]: got %h expected %h", i, rd, model_mem[widx(a)]); end
    end
  endtask
`else
  task automatic test_cti_ignored;
    int lat; logic [31:0] rd; logic bok, tok;
    wb_classic(1'b1, 32'h0000_3FF8, 32'h1, 4'hF, 3'b010, lat, rd, bok, tok);
    model_write(32'h0000_3FF8, 32'h1, 4'hF);
    checks++; if (lat != W + 1) begin errors++; $display("FAIL cti_wr_lat: got %0d expected %0d", lat, W + 1); end
    checks++; if (!tok) begin errors++; $display("FAIL cti_wr_tail: got 0 expected 1"); end
    wb_classic(1'b0, 32'h0000_0FF8, 32'h0, 4'hF, 3'b010, lat, rd, bok, tok);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL cti_rd: got %h expected 00000001", rd); end
  endtask
`endif

  task automatic test_reset_mid;
    int lat; logic [31:0] rd; logic bok, tok; logic seen;
    wb_classic(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 3'b000, lat, rd, bok, tok);
    model_write(32'h40, 32'hCAFEF00D, 4'hF);
    wb_classic(1'b0, 32'h10, 32'h0, 4'hF, 3'b000, lat, rd, bok, tok);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h40; dat = 32'h0BADC0DE; sel = 4'hF; cti = 3'b000;
    seen = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        seen = 1'b1;
        rstn = 1'b0;
        break;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_ack_seen: got 0 expected 1"); end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack: got %b expected 0", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (dato !== 32'h0) begin errors++; $display("FAIL rstmid_dat: got %h expected 00000000", dato); end
    @(posedge clk); #1;
    rstn = 1'b1;
    wb_classic(1'b0, 32'h40, 32'h0, 4'hF, 3'b000, lat, rd, bok, tok);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rstmid_ram: got %h expected cafef00d", rd); end
  endtask

  initial begin
    test_reset();
    test_classic();
    test_byte_enable();
    test_back_to_back(3'b000);
    test_abort();
    test_random();
`ifdef WB_RESP_BURST_EN
    test_burst_wrap();
    test_burst_wait();
`else
    test_cti_ignored();
    test_back_to_back(3'b010);
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
